// File: rtl/mem_req_queue.sv
// mem_req_queue: DEPTH-entry command FIFO feeding a single-outstanding memory
// request issuer, with an in-order, back-pressured read response register.
module mem_req_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32,
    parameter int TW    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_rnw_i,
    input  logic [AW-1:0]            cmd_addr_i,
    input  logic [DW-1:0]            cmd_wdata_i,
    input  logic [TW-1:0]            cmd_tag_i,
    output logic                     mem_req_o,
    output logic                     mem_rnw_o,
    output logic [AW-1:0]            mem_addr_o,
    output logic [DW-1:0]            mem_wdata_o,
    input  logic                     mem_ready_i,
    input  logic [DW-1:0]            mem_rdata_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DW-1:0]            rsp_rdata_o,
    output logic [TW-1:0]            rsp_tag_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t          state_r, next_state_s;
    logic            rnw_mem_r   [DEPTH];
    logic [AW-1:0]   addr_mem_r  [DEPTH];
    logic [DW-1:0]   wdata_mem_r [DEPTH];
    logic [TW-1:0]   tag_mem_r   [DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PW:0]     count_r;
    logic            push_s, issue_s, done_s;
    logic            mem_req_r, mem_rnw_r;
    logic [AW-1:0]   mem_addr_r;
    logic [DW-1:0]   mem_wdata_r;
    logic [TW-1:0]   issue_tag_r;
    logic            rsp_valid_r;
    logic [DW-1:0]   rsp_rdata_r;
    logic [TW-1:0]   rsp_tag_r;

    assign cmd_ready_o = (count_r < (PW+1)'(DEPTH));
    assign push_s      = cmd_valid_i && cmd_ready_o;
    assign count_o     = count_r;
    assign busy_o      = (count_r != (PW+1)'(0)) || mem_req_r || rsp_valid_r;
    assign mem_req_o   = mem_req_r;
    assign mem_rnw_o   = mem_rnw_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_tag_o   = rsp_tag_r;

    // Issuer next state; a read may only issue once the response slot is free or draining.
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if ((count_r != (PW+1)'(0)) &&
                    (!rnw_mem_r[rd_ptr_r] || !rsp_valid_r || rsp_ready_i)) begin
                    issue_s      = 1'b1;
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ready_i) begin
                    done_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = REQ;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Issuer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= (PW+1)'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, issue_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            rnw_mem_r[wr_ptr_r]   <= cmd_rnw_i;
            addr_mem_r[wr_ptr_r]  <= cmd_addr_i;
            wdata_mem_r[wr_ptr_r] <= cmd_wdata_i;
            tag_mem_r[wr_ptr_r]   <= cmd_tag_i;
        end
    end

    // Issue register, memory request and read response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_r   <= 1'b0;
            mem_rnw_r   <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            issue_tag_r <= {TW{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DW{1'b0}};
            rsp_tag_r   <= {TW{1'b0}};
        end else begin
            mem_req_r <= (next_state_s == REQ);
            if (issue_s) begin
                mem_rnw_r   <= rnw_mem_r[rd_ptr_r];
                mem_addr_r  <= addr_mem_r[rd_ptr_r];
                mem_wdata_r <= wdata_mem_r[rd_ptr_r];
                issue_tag_r <= tag_mem_r[rd_ptr_r];
            end
            if (done_s && mem_rnw_r) begin
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= mem_rdata_i;
                rsp_tag_r   <= issue_tag_r;
            end else if (rsp_ready_i) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end
endmodule
